approx_mult_err_monitor: RTL and testbench



---
 rtl/approx_mult_err_monitor.sv | 153 +++++++++++++++
 tb/tb_approx_mult_err_monitor.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_err_monitor.sv
// Error-statistics monitor for 8x8 approximate multipliers.
// Each accepted sample (A, B, R) goes through a three-stage pipeline: capture,
// exact-product/error-distance computation, then accumulation. Over a fixed
// window of NUM_SAMPLES samples it gathers the error count, the saturating sum
// of error distances and the largest error distance.
module approx_mult_err_monitor #(
  parameter int NUM_SAMPLES = 256,
  parameter int CNT_W       = 16,
  parameter int SUM_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       A,
  input  logic [7:0]       B,
  input  logic [15:0]      R,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] sum_ed,
  output logic [15:0]      max_ed
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  state_t state, state_nxt;
  logic   drain_cnt;

  logic        accept;
  logic        last_accept;
  logic        s1_valid;
  logic [7:0]  s1_a, s1_b;
  logic [15:0] s1_r;
  logic        s2_valid;
  logic        s2_flag;
  logic [15:0] s2_ed;

  logic [15:0]        prod;
  logic signed [16:0] diff;
  logic [15:0]        ed;
  logic [SUM_W:0]     sum_ext;

  assign accept      = (state == RUN) && in_valid;
  assign last_accept = accept && (sample_cnt == LAST_IDX);

  // State register plus the DRAIN cycle counter that times out the pipeline flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // Next-state logic: the window closes on its last acceptance, then waits two
  // cycles for the pipeline to empty before presenting results for one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_accept) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done <= (state_nxt == DONE);
    end
  end

  // Stage 1: capture the operands and the approximate result of an accepted sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_r     <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_a <= A;
        s1_b <= B;
        s1_r <= R;
      end
    end
  end

  // Exact product and absolute error distance; a 17-bit signed difference keeps the sign.
  always_comb begin
    prod = {8'd0, s1_a} * {8'd0, s1_b};
    diff = $signed({1'b0, prod}) - $signed({1'b0, s1_r});
    ed   = diff[16] ? 16'(-diff) : diff[15:0];
  end

  // Stage 2: register the error distance and whether this sample was wrong at all.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_flag  <= 1'b0;
      s2_ed    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_flag  <= (ed != 16'd0);
      s2_ed    <= ed;
    end
  end

  // One extra bit on the sum exposes overflow so the accumulator can saturate.
  assign sum_ext = {1'b0, sum_ed} + {{(SUM_W - 15){1'b0}}, s2_ed};

  // Sample counter: cleared when a window opens, stepped on every acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      sample_cnt <= '0;
    end else if (accept) begin
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

  // Stage 3: accumulate statistics; results are held after the window until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
    end else if ((state == IDLE) && start) begin
      err_cnt <= '0;
      sum_ed  <= '0;
      max_ed  <= '0;
    end else if (s2_valid) begin
      err_cnt <= err_cnt + CNT_W'(s2_flag);
      sum_ed  <= sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
      if (s2_ed > max_ed) max_ed <= s2_ed;
    end
  end

endmodule

// File: tb/tb_approx_mult_err_monitor.sv
// Testbench for approx_mult_err_monitor. Three instances share the stimulus:
// a 4-sample window with a 32-bit sum, a 4-sample window with a 16-bit
// saturating sum, and a 256-sample window. A reference model builds the
// expected window results as samples are driven and queues them; a monitor
// pops and compares them when the active instance pulses done.
module tb_approx_mult_err_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  a_in, b_in;
  logic [15:0] r_in;

  logic        busy_a, done_a, busy_b, done_b, busy_c, done_c;
  logic [15:0] sample_a, err_a, max_a, sample_b, err_b, max_b, sample_c, err_c, max_c;
  logic [31:0] sum_a, sum_c;
  logic [15:0] sum_b;

  typedef struct {
    longint cnt;
    longint err;
    longint sum;
    longint mx;
    longint done_cyc;
  } exp_t;

  exp_t   expq[$];
  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;
  int     active   = 0;

  bit     m_run = 0;
  longint m_ns, m_cnt, m_err, m_sum, m_max;

  approx_mult_err_monitor #(.NUM_SAMPLES(4), .CNT_W(16), .SUM_W(32)) dut_a (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .A(a_in), .B(b_in), .R(r_in),
    .busy(busy_a), .done(done_a), .sample_cnt(sample_a), .err_cnt(err_a), .sum_ed(sum_a), .max_ed(max_a));

  approx_mult_err_monitor #(.NUM_SAMPLES(4), .CNT_W(16), .SUM_W(16)) dut_b (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .A(a_in), .B(b_in), .R(r_in),
    .busy(busy_b), .done(done_b), .sample_cnt(sample_b), .err_cnt(err_b), .sum_ed(sum_b), .max_ed(max_b));

  approx_mult_err_monitor #(.NUM_SAMPLES(256), .CNT_W(16), .SUM_W(32)) dut_c (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .A(a_in), .B(b_in), .R(r_in),
    .busy(busy_c), .done(done_c), .sample_cnt(sample_c), .err_cnt(err_c), .sum_ed(sum_c), .max_ed(max_c));

  always #5 clk = ~clk;

  // Cycle counter used to time done pulses against the acceptance edges.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic checkWindow(input string tag, input longint cnt, input longint err,
                             input longint sum, input longint mx, input logic bsy,
                             input longint sum_max);
    exp_t e;
    if (expq.size() == 0) begin
      checkOutput({tag, "_unexpected_done"}, 1, 0);
    end else begin
      e = expq.pop_front();
      checkOutput({tag, "_done_cycle"}, cyc, e.done_cyc);
      checkOutput({tag, "_sample_cnt"}, cnt, e.cnt);
      checkOutput({tag, "_err_cnt"}, err, e.err);
      checkOutput({tag, "_sum_ed"}, sum, (e.sum > sum_max) ? sum_max : e.sum);
      checkOutput({tag, "_max_ed"}, mx, e.mx);
      checkOutput({tag, "_busy_at_done"}, longint'(bsy), 0);
    end
  endtask

  // Result monitor: only the instance whose window the model is tracking is graded.
  always @(negedge clk) begin
    if (!rst) begin
      if (done_a && active == 0)
        checkWindow("a", sample_a, err_a, sum_a, max_a, busy_a, 64'hFFFF_FFFF);
      if (done_b && active == 1)
        checkWindow("b", sample_b, err_b, sum_b, max_b, busy_b, 64'hFFFF);
      if (done_c && active == 2)
        checkWindow("c", sample_c, err_c, sum_c, max_c, busy_c, 64'hFFFF_FFFF);
    end
  end

  // Drive one valid sample for a cycle, then 'gap' idle cycles; called at a negedge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] r, input int gap);
    longint ed;
    in_valid = 1'b1;
    a_in = a;
    b_in = b;
    r_in = r;
    if (m_run) begin
      ed = longint'(a) * longint'(b) - longint'(r);
      if (ed < 0) ed = -ed;
      m_cnt++;
      if (ed != 0) m_err++;
      m_sum += ed;
      if (ed > m_max) m_max = ed;
      if (m_cnt == m_ns) begin
        expq.push_back('{cnt: m_cnt, err: m_err, sum: m_sum, mx: m_max, done_cyc: cyc + 3});
        m_run = 0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Open a window; a sample presented alongside start must not be counted.
  task automatic startWindow(input longint ns);
    start    = 1'b1;
    in_valid = 1'b1;
    a_in     = 8'd77;
    b_in     = 8'd3;
    r_in     = 16'd0;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b0;
    m_run = 1;
    m_ns  = ns;
    m_cnt = 0;
    m_err = 0;
    m_sum = 0;
    m_max = 0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("window_completed", expq.size(), 0);
    expq.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    m_run = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic runBasic(input int maxgap);
    applyStimulus(8'd10, 8'd10, 16'd100, $urandom_range(0, maxgap));
    applyStimulus(8'd255, 8'd255, 16'd65025, $urandom_range(0, maxgap));
    applyStimulus(8'd15, 8'd15, 16'd255, $urandom_range(0, maxgap));
    applyStimulus(8'd200, 8'd3, 16'd592, 0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    r_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_done", done_a, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_sample_cnt", sample_a, 0);
    checkOutput("reset_err_cnt", err_a, 0);
    checkOutput("reset_sum_ed", sum_a, 0);
    checkOutput("reset_max_ed", max_a, 0);

    $display("[TB] back-to-back window");
    active = 0;
    startWindow(4);
    checkOutput("busy_in_run", busy_a, 1);
    runBasic(0);
    waitDrain(20);
    checkOutput("held_sample_cnt", sample_a, 4);
    checkOutput("held_sum_ed", sum_a, 38);

    $display("[TB] gapped window with idle-state samples");
    applyStimulus(8'd1, 8'd2, 16'd9, 1);
    applyStimulus(8'd50, 8'd50, 16'd0, 0);
    startWindow(4);
    runBasic(3);
    waitDrain(30);

    $display("[TB] saturating 16-bit sum");
    active = 1;
    startWindow(4);
    for (int i = 0; i < 4; i++) applyStimulus(8'd255, 8'd255, 16'd0, 0);
    waitDrain(20);

    $display("[TB] start ignored in RUN and DRAIN");
    active = 0;
    startWindow(4);
    applyStimulus(8'd10, 8'd10, 16'd100, 0);
    applyStimulus(8'd15, 8'd15, 16'd255, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_run_start", busy_a, 1);
    checkOutput("cnt_after_run_start", sample_a, 2);
    applyStimulus(8'd255, 8'd255, 16'd65025, 0);
    applyStimulus(8'd200, 8'd3, 16'd592, 0);
    checkOutput("busy_in_drain", busy_a, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDrain(20);
    repeat (6) @(negedge clk);
    checkOutput("idle_after_window", busy_a, 0);
    checkOutput("held_cnt_idle", sample_a, 4);

    $display("[TB] asynchronous reset mid-window");
    startWindow(4);
    applyStimulus(8'd15, 8'd15, 16'd255, 0);
    applyStimulus(8'd200, 8'd3, 16'd592, 3);
    checkOutput("pre_reset_err_cnt", err_a, 2);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_sample_cnt", sample_a, 0);
    checkOutput("async_err_cnt", err_a, 0);
    checkOutput("async_sum_ed", sum_a, 0);
    checkOutput("async_max_ed", max_a, 0);
    checkOutput("async_busy", busy_a, 0);
    m_run = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("no_done_after_reset", expq.size(), 0);
    startWindow(4);
    runBasic(2);
    waitDrain(30);

    $display("[TB] 256 exact samples");
    doReset();
    active = 2;
    startWindow(256);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      applyStimulus(ra, rb, 16'(ra * rb), $urandom_range(0, 1));
    end
    waitDrain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
